// File: rtl/chif_frame_if.sv
// Byte-stream handshake bundle between the JTAG MAC FIFOs and the chif frame engine.
interface chif_frame_if;
    logic [7:0] chif_din;
    logic       chif_din_valid;
    logic       chif_din_ready;
    logic [7:0] chif_dout;
    logic       chif_dout_valid;
    logic       chif_dout_ready;

    modport master (
        output chif_din, chif_din_valid, chif_dout_ready,
        input  chif_din_ready, chif_dout, chif_dout_valid
    );

    modport slave (
        input  chif_din, chif_din_valid, chif_dout_ready,
        output chif_din_ready, chif_dout, chif_dout_valid
    );
endinterface

// File: rtl/chif_frame_engine.sv
// Chif-side frame engine: collects an input frame, runs the DUT N cycles, returns its output frame.
// Optional build macro CHIF_FRAME_LOOPBACK_EN captures dut_din instead of dut_dout.
module chif_frame_engine #(
    parameter int unsigned IN_BYTES  = 4,
    parameter int unsigned OUT_BYTES = 4
) (
    input  logic                   chif_clk,
    input  logic                   reset,
    chif_frame_if.slave            bus,
    input  logic [15:0]            chif_simcycle,
    output logic [IN_BYTES*8-1:0]  dut_din,
    output logic                   dut_clk_en,
    input  logic [OUT_BYTES*8-1:0] dut_dout,
    output logic                   err_overflow
);
    typedef enum logic [1:0] {COLLECT, RUN, CAPTURE, SEND} state_t;

    localparam logic [6:0]  IN_N      = 7'(IN_BYTES);
    localparam logic [6:0]  OUT_N     = 7'(OUT_BYTES);
    localparam int unsigned MIN_BYTES = (IN_BYTES < OUT_BYTES) ? IN_BYTES : OUT_BYTES;

    state_t                 r_state, w_next;
    logic [6:0]             r_byte_cnt, r_out_cnt;
    logic                   r_rdy_d1;
    logic [15:0]            r_cyc_left;
    logic [OUT_BYTES*8-1:0] r_out_sr, w_cap;
    logic [IN_BYTES*8-1:0]  r_dut_din;
    logic [7:0]             r_dout;
    logic                   r_dout_valid, r_err;
    logic                   w_din_ready, w_accept, w_last_in, w_send, w_clk_en;

    // rdy_d1 counts the byte already requested but not yet delivered
    assign w_din_ready = (r_state == COLLECT) && !reset &&
                         ((r_byte_cnt + {6'd0, r_rdy_d1}) < IN_N);
    assign w_accept    = bus.chif_din_valid && (r_state == COLLECT) && (r_byte_cnt < IN_N);
    assign w_last_in   = w_accept && (r_byte_cnt == IN_N - 7'd1);
    assign w_send      = (r_state == SEND) && bus.chif_dout_ready && (r_out_cnt < OUT_N);

`ifdef CHIF_FRAME_LOOPBACK_EN
    always_comb begin
        w_cap = '0;
        for (int unsigned i = 0; i < MIN_BYTES; i++) begin
            w_cap[8*i +: 8] = r_dut_din[8*i +: 8];
        end
    end
`else
    assign w_cap = dut_dout;
`endif

    always_ff @(posedge chif_clk) begin
        if (reset) r_state <= COLLECT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_clk_en = 1'b0;
        case (r_state)
            COLLECT: if (w_last_in) w_next = RUN;
            RUN: begin
                w_clk_en = 1'b1;
                if (r_cyc_left <= 16'd1) w_next = CAPTURE;
            end
            CAPTURE: w_next = SEND;
            SEND:    if (w_send && (r_out_cnt == OUT_N - 7'd1)) w_next = COLLECT;
            default: w_next = COLLECT;
        endcase
    end

    always_ff @(posedge chif_clk) begin
        if (reset) begin
            r_byte_cnt   <= '0;
            r_out_cnt    <= '0;
            r_rdy_d1     <= 1'b0;
            r_cyc_left   <= '0;
            r_out_sr     <= '0;
            r_dut_din    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rdy_d1     <= w_din_ready;
            r_dout_valid <= 1'b0;
            if (bus.chif_din_valid && !w_accept) r_err <= 1'b1;
            case (r_state)
                COLLECT: if (w_accept) begin
                    for (int unsigned i = 0; i < IN_BYTES; i++) begin
                        if (r_byte_cnt == 7'(i)) r_dut_din[8*i +: 8] <= bus.chif_din;
                    end
                    r_byte_cnt <= r_byte_cnt + 7'd1;
                    if (w_last_in)
                        r_cyc_left <= (chif_simcycle == 16'd0) ? 16'd1 : chif_simcycle;
                end
                RUN: r_cyc_left <= r_cyc_left - 16'd1;
                CAPTURE: begin
                    r_out_sr  <= w_cap;
                    r_out_cnt <= '0;
                end
                SEND: if (w_send) begin
                    r_dout       <= r_out_sr[7:0];
                    r_dout_valid <= 1'b1;
                    r_out_sr     <= r_out_sr >> 8;
                    r_out_cnt    <= r_out_cnt + 7'd1;
                    if (r_out_cnt == OUT_N - 7'd1) r_byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.chif_din_ready  = w_din_ready;
    assign bus.chif_dout       = r_dout;
    assign bus.chif_dout_valid = r_dout_valid;
    assign dut_din             = r_dut_din;
    assign dut_clk_en          = w_clk_en;
    assign err_overflow        = r_err;
endmodule
